// File: rtl/demux_guarded_nout.sv
// Registered 1-to-NOUT demux of y with a break-before-make guard on channel changes.
// Latency: x carries y one clk later; a switch shows exactly DEAD_CYCLES idle cycles.
// No backpressure: sel_load is a strobe, and a new strobe during the guard restarts it.
module demux_guarded_nout #(
    parameter int   NOUT        = 4,
    parameter int   SEL_W       = 2,
    parameter int   DEAD_CYCLES = 2,
    parameter logic IDLE_LEVEL  = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    input  logic             sel_load,
    input  logic             y,
    output logic [NOUT-1:0]  x,
    output logic [SEL_W-1:0] active_sel,
    output logic             routing,
    output logic             busy
);

    typedef enum logic [1:0] {S_OFF, S_GUARD, S_ON} state_t;

    localparam logic [SEL_W:0]   NOUT_L = (SEL_W + 1)'(NOUT);
    localparam int               LAST_I = (DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0;
    localparam logic [7:0]       LAST   = LAST_I[7:0];
    localparam logic [NOUT-1:0]  IDLE_V = {NOUT{IDLE_LEVEL}};

    state_t           state, state_n;
    logic [7:0]       cnt, cnt_n;
    logic [SEL_W-1:0] target, target_n, active_n;
    logic [NOUT-1:0]  x_n;
    logic             routing_n, busy_n;
    logic             legal;

    assign legal = ({1'b0, sel} < NOUT_L);

    function automatic logic [NOUT-1:0] route(input logic [SEL_W-1:0] ch, input logic d);
        logic [NOUT-1:0] v;
        v = IDLE_V;
        for (int i = 0; i < NOUT; i++) begin
            if (ch == SEL_W'(i)) v[i] = d;
        end
        return v;
    endfunction

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        target_n  = target;
        active_n  = active_sel;
        x_n       = IDLE_V;
        routing_n = 1'b0;
        busy_n    = 1'b0;
        if (!en) begin
            state_n = S_OFF;
            cnt_n   = 8'd0;
        end else begin
            case (state)
                S_OFF: begin
                    if (sel_load && legal) begin
                        target_n = sel;
                        if (DEAD_CYCLES == 0) begin
                            state_n   = S_ON;
                            active_n  = sel;
                            x_n       = route(sel, y);
                            routing_n = 1'b1;
                        end else begin
                            state_n = S_GUARD;
                            cnt_n   = 8'd0;
                            busy_n  = 1'b1;
                        end
                    end
                end
                S_ON: begin
                    x_n       = route(active_sel, y);
                    routing_n = 1'b1;
                    if (sel_load) begin
                        if (!legal) begin
                            state_n   = S_OFF;
                            x_n       = IDLE_V;
                            routing_n = 1'b0;
                        end else if (sel != active_sel) begin
                            target_n = sel;
                            // Zero guard: old output drops in the same cycle the new one goes live.
                            if (DEAD_CYCLES == 0) begin
                                active_n = sel;
                                x_n      = route(sel, y);
                            end else begin
                                state_n   = S_GUARD;
                                cnt_n     = 8'd0;
                                busy_n    = 1'b1;
                                x_n       = IDLE_V;
                                routing_n = 1'b0;
                            end
                        end
                    end
                end
                S_GUARD: begin
                    busy_n = 1'b1;
                    if (sel_load && !legal) begin
                        state_n = S_OFF;
                        cnt_n   = 8'd0;
                        busy_n  = 1'b0;
                    end else if (sel_load) begin
                        target_n = sel;
                        cnt_n    = 8'd0;
                    end else if (cnt == LAST) begin
                        state_n   = S_ON;
                        active_n  = target;
                        x_n       = route(target, y);
                        routing_n = 1'b1;
                        busy_n    = 1'b0;
                        cnt_n     = 8'd0;
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
                default: begin
                    state_n = S_OFF;
                    cnt_n   = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_OFF;
            cnt        <= 8'd0;
            target     <= '0;
            active_sel <= '0;
            x          <= IDLE_V;
            routing    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            target     <= target_n;
            active_sel <= active_n;
            x          <= x_n;
            routing    <= routing_n;
            busy       <= busy_n;
        end
    end

    // At most one output may differ from idle, and none when not routing.
    a_one_hot: assert property (@(posedge clk) disable iff (!reset_n)
        routing ? ($countones(x ^ IDLE_V) <= 1) : (x == IDLE_V));

endmodule

// File: tb/tb_demux_guarded_nout.sv
// Bench for demux_guarded_nout: three parameter sets share inputs; each scenario
// queues stimulus rows, pushes the expected post-edge outputs to a scoreboard and compares.
module tb_demux_guarded_nout;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic en = 1'b0;
    logic [1:0] sel = 2'd0;
    logic sel_load = 1'b0;
    logic y = 1'b0;

    logic [3:0] xa, xc;
    logic [2:0] xb;
    logic [1:0] asa, asb, asc;
    logic ra, rb, rc, ba, bb, bc;

    always #5 clk = ~clk;

    demux_guarded_nout #(.NOUT(4), .SEL_W(2), .DEAD_CYCLES(2), .IDLE_LEVEL(1'b0)) dut_a (
        .clk(clk), .reset_n(reset_n), .en(en), .sel(sel), .sel_load(sel_load), .y(y),
        .x(xa), .active_sel(asa), .routing(ra), .busy(ba));
    demux_guarded_nout #(.NOUT(3), .SEL_W(2), .DEAD_CYCLES(2), .IDLE_LEVEL(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n), .en(en), .sel(sel), .sel_load(sel_load), .y(y),
        .x(xb), .active_sel(asb), .routing(rb), .busy(bb));
    demux_guarded_nout #(.NOUT(4), .SEL_W(2), .DEAD_CYCLES(0), .IDLE_LEVEL(1'b1)) dut_c (
        .clk(clk), .reset_n(reset_n), .en(en), .sel(sel), .sel_load(sel_load), .y(y),
        .x(xc), .active_sel(asc), .routing(rc), .busy(bc));

    typedef struct packed {
        logic [3:0] x;
        logic       busy;
        logic       routing;
        logic [1:0] as;
    } exp_t;

    typedef struct {
        logic       rn, en, sl;
        logic [1:0] sel;
        logic       y;
        exp_t       e;
    } row_t;

    row_t rows[$];
    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   which = 0;   // 0: 4-out guard 2, 1: 3-out guard 2, 2: 4-out no guard idle-high

    function automatic exp_t observed();
        exp_t o;
        case (which)
            0:       o = {xa, ba, ra, asa};
            1:       o = {1'b0, xb, bb, rb, asb};
            default: o = {xc, bc, rc, asc};
        endcase
        return o;
    endfunction

    // ch = -1 means every output of the selected DUT is expected idle.
    task automatic add(input logic rn, input logic e, input logic sl, input logic [1:0] s,
                       input int ch, input logic eb, input logic er, input logic [1:0] ea);
        row_t r;
        int   n;
        logic idle;
        n      = (which == 1) ? 3 : 4;
        idle   = (which == 2);
        r.rn   = rn;
        r.en   = e;
        r.sl   = sl;
        r.sel  = s;
        r.y    = 1'($urandom_range(0, 1));
        r.e.x  = 4'b0000;
        for (int i = 0; i < n; i++) r.e.x[i] = (i == ch) ? r.y : idle;
        r.e.busy    = eb;
        r.e.routing = er;
        r.e.as      = ea;
        rows.push_back(r);
    endtask

    task automatic test_reset();
        row_t r; exp_t e, o; int k;
        which = 0; k = 0;
        add(0, 1, 1, 2, -1, 0, 0, 0);
        add(0, 1, 1, 2, -1, 0, 0, 0);
        while (rows.size() > 0) begin
            r = rows.pop_front();
            reset_n = r.rn; en = r.en; sel_load = r.sl; sel = r.sel; y = r.y;
            sb.push_back(r.e);
            @(posedge clk); #1;
            e = sb.pop_front(); o = observed(); n_chk++; k++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL test_reset step %0d: got %b want %b (x,busy,routing,active_sel)", k, o, e);
            end
        end
    endtask

    task automatic test_route();
        row_t r; exp_t e, o; int k;
        which = 0; k = 0;
        add(1, 1, 1, 2, -1, 1, 0, 0);
        add(1, 1, 0, 0, -1, 1, 0, 0);
        repeat (5) add(1, 1, 0, 0, 2, 0, 1, 2);
        while (rows.size() > 0) begin
            r = rows.pop_front();
            reset_n = r.rn; en = r.en; sel_load = r.sl; sel = r.sel; y = r.y;
            sb.push_back(r.e);
            @(posedge clk); #1;
            e = sb.pop_front(); o = observed(); n_chk++; k++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL test_route step %0d: got %b want %b (x,busy,routing,active_sel)", k, o, e);
            end
        end
    endtask

    task automatic test_switch();
        row_t r; exp_t e, o; int k;
        which = 0; k = 0;
        add(1, 1, 1, 0, -1, 1, 0, 2);
        add(1, 1, 0, 0, -1, 1, 0, 2);
        repeat (4) add(1, 1, 0, 0, 0, 0, 1, 0);
        while (rows.size() > 0) begin
            r = rows.pop_front();
            reset_n = r.rn; en = r.en; sel_load = r.sl; sel = r.sel; y = r.y;
            sb.push_back(r.e);
            @(posedge clk); #1;
            e = sb.pop_front(); o = observed(); n_chk++; k++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL test_switch step %0d: got %b want %b (x,busy,routing,active_sel)", k, o, e);
            end
        end
    endtask

    task automatic test_same_sel();
        row_t r; exp_t e, o; int k;
        which = 0; k = 0;
        add(1, 1, 1, 1, -1, 1, 0, 0);
        add(1, 1, 0, 0, -1, 1, 0, 0);
        add(1, 1, 0, 0, 1, 0, 1, 1);
        repeat (3) add(1, 1, 1, 1, 1, 0, 1, 1);
        add(1, 1, 0, 0, 1, 0, 1, 1);
        while (rows.size() > 0) begin
            r = rows.pop_front();
            reset_n = r.rn; en = r.en; sel_load = r.sl; sel = r.sel; y = r.y;
            sb.push_back(r.e);
            @(posedge clk); #1;
            e = sb.pop_front(); o = observed(); n_chk++; k++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL test_same_sel step %0d: got %b want %b (x,busy,routing,active_sel)", k, o, e);
            end
        end
    endtask

    task automatic test_restart();
        row_t r; exp_t e, o; int k;
        which = 0; k = 0;
        add(1, 1, 1, 3, -1, 1, 0, 1);
        add(1, 1, 1, 1, -1, 1, 0, 1);
        add(1, 1, 0, 0, -1, 1, 0, 1);
        repeat (3) add(1, 1, 0, 0, 1, 0, 1, 1);
        while (rows.size() > 0) begin
            r = rows.pop_front();
            reset_n = r.rn; en = r.en; sel_load = r.sl; sel = r.sel; y = r.y;
            sb.push_back(r.e);
            @(posedge clk); #1;
            e = sb.pop_front(); o = observed(); n_chk++; k++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL test_restart step %0d: got %b want %b (x,busy,routing,active_sel)", k, o, e);
            end
        end
    endtask

    task automatic test_off();
        row_t r; exp_t e, o; int k;
        which = 1; k = 0;
        add(0, 0, 0, 0, -1, 0, 0, 0);
        add(1, 1, 1, 3, -1, 0, 0, 0);   // out-of-range strobe from OFF ignored
        add(1, 1, 1, 1, -1, 1, 0, 0);
        add(1, 1, 0, 0, -1, 1, 0, 0);
        add(1, 1, 0, 0, 1, 0, 1, 1);
        add(1, 1, 1, 3, -1, 0, 0, 1);   // out-of-range while routing -> OFF
        add(1, 0, 1, 0, -1, 0, 0, 1);   // en low beats strobe
        add(1, 1, 0, 0, -1, 0, 0, 1);
        add(1, 1, 1, 2, -1, 1, 0, 1);
        add(1, 0, 0, 0, -1, 0, 0, 1);   // en low mid-guard
        add(1, 1, 0, 0, -1, 0, 0, 1);
        add(1, 1, 1, 0, -1, 1, 0, 1);
        add(1, 1, 1, 3, -1, 0, 0, 1);   // out-of-range mid-guard -> OFF
        add(1, 1, 0, 0, -1, 0, 0, 1);
        while (rows.size() > 0) begin
            r = rows.pop_front();
            reset_n = r.rn; en = r.en; sel_load = r.sl; sel = r.sel; y = r.y;
            sb.push_back(r.e);
            @(posedge clk); #1;
            e = sb.pop_front(); o = observed(); n_chk++; k++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL test_off step %0d: got %b want %b (x,busy,routing,active_sel)", k, o, e);
            end
        end
    endtask

    task automatic test_reset_guard();
        row_t r; exp_t e, o; int k;
        which = 0; k = 0;
        add(0, 0, 0, 0, -1, 0, 0, 0);
        add(1, 1, 1, 2, -1, 1, 0, 0);
        add(1, 1, 0, 0, -1, 1, 0, 0);
        add(1, 1, 0, 0, 2, 0, 1, 2);
        add(1, 1, 1, 0, -1, 1, 0, 2);
        add(0, 1, 0, 0, -1, 0, 0, 0);
        add(1, 1, 0, 0, -1, 0, 0, 0);
        add(1, 1, 0, 0, -1, 0, 0, 0);
        while (rows.size() > 0) begin
            r = rows.pop_front();
            reset_n = r.rn; en = r.en; sel_load = r.sl; sel = r.sel; y = r.y;
            sb.push_back(r.e);
            @(posedge clk); #1;
            e = sb.pop_front(); o = observed(); n_chk++; k++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL test_reset_guard step %0d: got %b want %b (x,busy,routing,active_sel)", k, o, e);
            end
        end
    endtask

    task automatic test_idle_high();
        row_t r; exp_t e, o; int k;
        which = 2; k = 0;
        add(0, 1, 0, 0, -1, 0, 0, 0);
        add(1, 1, 1, 2, 2, 0, 1, 2);
        add(1, 1, 0, 0, 2, 0, 1, 2);
        add(1, 1, 1, 1, 1, 0, 1, 1);
        add(1, 1, 0, 0, 1, 0, 1, 1);
        add(1, 0, 0, 0, -1, 0, 0, 1);
        add(1, 1, 0, 0, -1, 0, 0, 1);
        add(1, 1, 1, 3, 3, 0, 1, 3);
        add(1, 1, 1, 0, 0, 0, 1, 0);
        add(1, 1, 0, 0, 0, 0, 1, 0);
        while (rows.size() > 0) begin
            r = rows.pop_front();
            reset_n = r.rn; en = r.en; sel_load = r.sl; sel = r.sel; y = r.y;
            sb.push_back(r.e);
            @(posedge clk); #1;
            e = sb.pop_front(); o = observed(); n_chk++; k++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL test_idle_high step %0d: got %b want %b (x,busy,routing,active_sel)", k, o, e);
            end
        end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_route();
        test_switch();
        test_same_sel();
        test_restart();
        test_off();
        test_reset_guard();
        test_idle_high();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_guarded_nout.md
Name: demux_guarded_nout

Overview:
- Registered, parametrised 1-to-N demultiplexer: routes a single-bit signal `y` (e.g. a modulation or demod bit) to one of NOUT outputs.
- Channel changes pass through a programmable break-before-make guard interval. During the guard all outputs are held at an idle level, so no two outputs carry `y` in the same cycle and no output glitches during a switch.
- Sits between the mode-select logic and the per-mode receive/transmit paths in the FPGA top level.

Parameters:
- NOUT, 4, number of outputs; legal range 2..16.
- SEL_W, 2, width of `sel`; must satisfy 2^SEL_W >= NOUT.
- DEAD_CYCLES, 2, guard length in clk cycles; 0 = direct switch, max 255.
- IDLE_LEVEL, 0, level driven on every unselected or disabled output.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous reset, active-low.
- en  in  1  global enable; low forces the OFF state.
- sel  in  SEL_W  requested channel index.
- sel_load  in  1  one-cycle strobe; samples `sel`.
- y  in  1  data to route.
- x  out  NOUT  demultiplexed outputs (registered).
- active_sel  out  SEL_W  currently routed channel; valid only when `routing`=1.
- routing  out  1  high when some `x` bit carries `y`.
- busy  out  1  high during GUARD.

Behaviour:
- Reset (reset_n=0 at a clk edge): state=OFF, x=all IDLE_LEVEL, active_sel=0, routing=0, busy=0, guard counter=0, pending target=0. Reset has priority over every other input, including mid-guard.
- The design is fully synchronous. All outputs are registered and there are no latches: every output is assigned on every path.
- States:
  - OFF: x=idle, routing=0.
    - sel_load=1 with en=1 and sel<NOUT: target<=sel. Go to GUARD if DEAD_CYCLES>0, else go directly to ON.
    - sel_load with sel>=NOUT is ignored.
  - ON: x[active_sel] = y delayed by exactly 1 clk; every other bit = IDLE_LEVEL; routing=1.
    - sel_load with sel==active_sel: ignored, no guard.
    - sel_load with a different legal sel: target<=sel, x<=all idle on the next edge, enter GUARD.
    - With DEAD_CYCLES=0: switch straight to the new channel; the old output is idle in the same cycle the new one goes live.
    - sel_load with sel>=NOUT: go to OFF.
  - GUARD: busy=1, routing=0, x=all idle. Counter counts DEAD_CYCLES cycles, then ON with active_sel<=target.
    - Idle cycles between the last old-channel sample and the first new-channel sample = DEAD_CYCLES exactly.
    - A new legal sel_load during GUARD: updates target and restarts the counter.
    - sel_load with sel>=NOUT during GUARD: go to OFF.
- en=0 in any state: next edge goes to OFF, x=idle, busy=0, counter cleared. sel_load is ignored while en=0.
- en rising alone does not resume routing; a sel_load is required.
- Simultaneous en=0 and sel_load: en wins.
- active_sel holds its last routed value in OFF and GUARD.
- Invariant, checked by assertion: popcount(x XOR {NOUT{IDLE_LEVEL}}) <= 1 whenever routing=1, and = 0 otherwise.

Test Plan:
1. Reset, then en=1, sel_load with sel=2 (DEAD_CYCLES=2) -> busy=1 for 2 cycles; then routing=1, active_sel=2, x[2] follows y with 1-cycle lag; x[0],x[1],x[3]=0.
2. Routing ch 2, sel_load sel=0 -> x all 0 for exactly 2 cycles; then x[0] follows y; x[2] never high after the strobe edge.
3. Routing ch 1, sel_load sel=1 -> no guard, busy stays 0, x[1] continuous with no idle gap.
4. GUARD toward ch 3, sel_load sel=1 one cycle in -> counter restarts; ch 1 live 2 cycles after the second strobe; x[3] never asserted.
5. NOUT=3, sel_load sel=3 while routing -> OFF, x=000, routing=0. Then en=0 with a simultaneous sel_load sel=0 -> stays OFF.
6. reset_n=0 mid-GUARD, then released -> x all IDLE_LEVEL, busy=0, routing=0, active_sel=0. Repeat with IDLE_LEVEL=1 and DEAD_CYCLES=0 -> idle bits=1 and switches take effect on the next edge.
